multi_counter: RTL and testbench
================================

Name: multi_counter

Overview:
- Parametrised successor to the single-channel interval counter.
- Provides NUM_CH independent channels. Each channel has:
  - a prescaler (tic) that advances the channel counter once every interval+1 RUN cycles;
  - a programmable terminal count (limit);
  - wrap or one-shot mode;
  - tick and done strobes.
- Sits beside the CPU-side control logic as the system timer/event counter bank; software drives per-channel state codes.

Parameters:
- NUM_CH, 4, number of independent channels (>=1)
- WIDTH, 32, width of tic, interval, limit and counter per channel
- STATE_W, 8, width of each channel's state code

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset, all channels
- state  in  STATE_W*NUM_CH  per-channel command; channel i at [i*STATE_W +: STATE_W]
- interval  in  WIDTH*NUM_CH  per-channel prescale compare value
- limit  in  WIDTH*NUM_CH  per-channel terminal count
- mode  in  NUM_CH  per-channel mode: 0 = WRAP, 1 = ONESHOT
- counter  out  WIDTH*NUM_CH  per-channel count value (registered)
- tick  out  NUM_CH  one-cycle pulse, asserted with the edge that increments counter
- done  out  NUM_CH  WRAP: one-cycle pulse on wrap; ONESHOT: sticky terminal flag

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- rst=1: every channel sets tic=0, counter=0, tick=0, done=0. rst overrides any state code.
- State codes: 8'd0 RESET, 8'd1 RUN, 8'd2 HALT. Any other code behaves as HALT.
- RESET (per channel): tic=0, counter=0, tick=0, done=0. Same effect as rst but for that channel only.
- HALT: tic, counter and done hold; tick=0.
  - A RUN→HALT→RUN sequence resumes from the held tic; no cycle is lost or duplicated.
- RUN, prescaler:
  - Increment event when tic >= interval. Then tic<=0.
  - Otherwise tic<=tic+1.
  - ">=" (not "==") is required: if interval is lowered mid-run below the current tic, the event fires next cycle instead of waiting for 2^WIDTH wrap.
  - interval=0 gives an event every RUN cycle. Period = interval+1 cycles.
- RUN, WRAP mode, on an event:
  - counter >= limit: counter<=0, done pulses 1 cycle.
  - Otherwise: counter<=counter+1, done=0.
  - tick pulses 1 cycle on every event.
  - With limit=L the counter sequence is 0..L, then 0.
- RUN, ONESHOT mode:
  - While done=0 and counter >= limit (including limit=0 at start): done<=1 with no increment; tic is held.
  - Otherwise an event increments counter. When counter+1 == limit, done<=1 on the same edge, so counter==limit and done rise together.
  - Once done=1: tic and counter freeze, tick=0.
  - done clears only via RESET or rst. Switching mode to WRAP while done=1 resumes counting from the held counter; done then behaves as the WRAP pulse.
- Counter arithmetic: modulo 2^WIDTH. In WRAP mode with limit=2^WIDTH-1, natural overflow coincides with the wrap.
- Channels are fully independent; there are no cross-channel interactions.
- Input changes (interval, limit, mode, state) take effect on the next rising edge; no input is captured or latched.
- Latency: the event edge updates counter, tick and done together, i.e. 0 extra cycles beyond the registered update.

Decomposition:
- Package counter_pkg:
  - STATE_RESET, STATE_RUN, STATE_HALT constants (STATE_W wide);
  - MODE_WRAP, MODE_ONESHOT constants.
- Sub-module counter_channel: one channel's tic/counter/tick/done logic, parameterised by WIDTH and STATE_W.
- multi_counter instantiates NUM_CH copies in a generate loop and slices the flat buses.

Test Plan:
- rst=1 for 2 cycles with all channels commanded RUN -> all counter=0, tick=0, done=0; with rst=0, channel 0 in RUN, interval=3, WRAP, limit=100 -> counter=1 at the 4th RUN edge, tick high for exactly that cycle, then every 4 cycles.
- WRAP, interval=0, limit=2, 7 RUN cycles -> counter 1,2,0,1,2,0,1; done pulses on the two edges where counter returns to 0.
- ONESHOT, interval=1, limit=3 -> counter reaches 3 after 6 RUN cycles with done=1 on that edge; 10 further RUN cycles -> counter stays 3, tick=0, done=1; RESET -> counter=0, done=0.
- Channel 1 RUN interval=4: HALT after 2 RUN cycles (tic=2) for 5 cycles, then RUN -> first increment 3 RUN cycles after resume; counter and tic unchanged during HALT; channel 2 in RUN unaffected.
- interval lowered from 10 to 2 while tic=7 -> event on the next edge, tic=0, counter+1; ONESHOT with limit=0 -> done=1 after 1 RUN cycle, counter stays 0.
- state=8'd5 on a running channel -> behaves as HALT; WRAP with limit=2^WIDTH-1 (WIDTH=4 instance) -> counter 15→0 with a done pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared state codes and mode encodings for the multi-channel interval counter bank.
package counter_pkg;

    localparam int unsigned STATE_CODE_W = 8;

    localparam logic [STATE_CODE_W-1:0] STATE_RESET = 8'd0;
    localparam logic [STATE_CODE_W-1:0] STATE_RUN   = 8'd1;
    localparam logic [STATE_CODE_W-1:0] STATE_HALT  = 8'd2;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/counter_channel.sv
// One independent channel: prescaler (tic), terminal-count counter, tick and done strobes.
module counter_channel
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STATE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] state,
    input  logic [WIDTH-1:0]   interval,
    input  logic [WIDTH-1:0]   limit,
    input  logic               mode,
    output logic [WIDTH-1:0]   counter,
    output logic               tick,
    output logic               done
);

    logic [WIDTH-1:0] tic;
    logic [WIDTH-1:0] tic_d;
    logic [WIDTH-1:0] counter_d;
    logic             tick_d;
    logic             done_d;

    logic             cmd_reset;
    logic             cmd_run;
    logic             event_hit;
    logic             at_limit;
    logic [WIDTH-1:0] counter_inc;

    // Unknown codes fall through to HALT because only RESET and RUN are decoded.
    assign cmd_reset   = (state == STATE_W'(STATE_RESET));
    assign cmd_run     = (state == STATE_W'(STATE_RUN));
    assign event_hit   = (tic >= interval);
    assign at_limit    = (counter >= limit);
    assign counter_inc = counter + WIDTH'(1);

    // Next-state: everything holds and tick drops unless RUN says otherwise.
    always_comb begin
        tic_d     = tic;
        counter_d = counter;
        tick_d    = 1'b0;
        done_d    = done;

        if (cmd_reset) begin
            tic_d     = '0;
            counter_d = '0;
            done_d    = 1'b0;
        end else if (cmd_run) begin
            if (mode == MODE_ONESHOT) begin
                if (!done) begin
                    if (at_limit) begin
                        // Already at terminal count: flag it, no increment, tic held.
                        done_d = 1'b1;
                    end else if (event_hit) begin
                        tic_d     = '0;
                        counter_d = counter_inc;
                        tick_d    = 1'b1;
                        done_d    = (counter_inc == limit);
                    end else begin
                        tic_d = tic + WIDTH'(1);
                    end
                end
            end else begin
                done_d = 1'b0;
                if (event_hit) begin
                    tic_d  = '0;
                    tick_d = 1'b1;
                    if (at_limit) begin
                        counter_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        counter_d = counter_inc;
                    end
                end else begin
                    tic_d = tic + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tic     <= '0;
            counter <= '0;
            tick    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tic     <= tic_d;
            counter <= counter_d;
            tick    <= tick_d;
            done    <= done_d;
        end
    end

endmodule

// File: rtl/multi_counter.sv
// Bank of NUM_CH independent interval counters sharing one clock and reset.
module multi_counter
    import counter_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STATE_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STATE_W*NUM_CH-1:0]  state,
    input  logic [WIDTH*NUM_CH-1:0]    interval,
    input  logic [WIDTH*NUM_CH-1:0]    limit,
    input  logic [NUM_CH-1:0]          mode,
    output logic [WIDTH*NUM_CH-1:0]    counter,
    output logic [NUM_CH-1:0]          tick,
    output logic [NUM_CH-1:0]          done
);

    // Channel i owns slice [i*W +: W] of every flat bus.
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        counter_channel #(
            .WIDTH   (WIDTH),
            .STATE_W (STATE_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .state    (state[i*STATE_W +: STATE_W]),
            .interval (interval[i*WIDTH +: WIDTH]),
            .limit    (limit[i*WIDTH +: WIDTH]),
            .mode     (mode[i]),
            .counter  (counter[i*WIDTH +: WIDTH]),
            .tick     (tick[i]),
            .done     (done[i])
        );
    end

endmodule

// File: tb/tb_multi_counter.sv
// Randomised and directed checks of multi_counter against a behavioural channel model.
module tb_multi_counter;

    localparam int NCH = 4;
    localparam int W   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  st  [NCH];
    logic [31:0] iv  [NCH];
    logic [31:0] lim [NCH];
    logic        md  [NCH];

    logic [8*NCH-1:0]  state_bus;
    logic [W*NCH-1:0]  iv_bus, lim_bus, cnt_bus;
    logic [NCH-1:0]    mode_bus, tick_bus, done_bus;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_bus[i*8 +: 8] = st[i];
            iv_bus[i*W +: W]    = iv[i];
            lim_bus[i*W +: W]   = lim[i];
            mode_bus[i]         = md[i];
        end
    end

    multi_counter #(.NUM_CH(NCH), .WIDTH(W), .STATE_W(8)) dut (
        .clk(clk), .rst(rst), .state(state_bus), .interval(iv_bus), .limit(lim_bus),
        .mode(mode_bus), .counter(cnt_bus), .tick(tick_bus), .done(done_bus)
    );

    // Narrow instance for the natural-overflow boundary.
    logic [7:0] st_s;
    logic [3:0] iv_s, lim_s, cnt_s;
    logic [0:0] md_s, tick_s, done_s;

    multi_counter #(.NUM_CH(1), .WIDTH(4), .STATE_W(8)) dut_s (
        .clk(clk), .rst(rst), .state(st_s), .interval(iv_s), .limit(lim_s),
        .mode(md_s), .counter(cnt_s), .tick(tick_s), .done(done_s)
    );

    // Reference state
    logic [31:0] m_tic [NCH+1];
    logic [31:0] m_cnt [NCH+1];
    logic        m_tick[NCH+1];
    logic        m_done[NCH+1];

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of a channel from the rules: reset, run (prescale, wrap/oneshot), otherwise hold.
    task automatic model_ch(input int k, input logic [7:0] s, input logic [31:0] ivv,
                            input logic [31:0] limv, input logic mdv, input logic [31:0] mask);
        logic [31:0] nxt;
        if (rst || s == 8'd0) begin
            m_tic[k] = 0; m_cnt[k] = 0; m_tick[k] = 0; m_done[k] = 0;
        end else if (s != 8'd1) begin
            m_tick[k] = 0;
        end else if (mdv) begin
            m_tick[k] = 0;
            if (m_done[k]) begin
                // frozen
            end else if (m_cnt[k] >= limv) begin
                m_done[k] = 1;
            end else if (m_tic[k] >= ivv) begin
                nxt = (m_cnt[k] + 1) & mask;
                m_tic[k] = 0; m_cnt[k] = nxt; m_tick[k] = 1; m_done[k] = (nxt == limv);
            end else begin
                m_tic[k] = (m_tic[k] + 1) & mask;
            end
        end else begin
            m_done[k] = 0; m_tick[k] = 0;
            if (m_tic[k] >= ivv) begin
                m_tic[k] = 0; m_tick[k] = 1;
                if (m_cnt[k] >= limv) begin m_cnt[k] = 0; m_done[k] = 1; end
                else m_cnt[k] = (m_cnt[k] + 1) & mask;
            end else begin
                m_tic[k] = (m_tic[k] + 1) & mask;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < NCH; i++) model_ch(i, st[i], iv[i], lim[i], md[i], 32'hFFFF_FFFF);
        model_ch(NCH, st_s, {28'd0, iv_s}, {28'd0, lim_s}, md_s[0], 32'h0000_000F);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_ch(input int c, input logic [7:0] s, input logic [31:0] ivv,
                          input logic [31:0] limv, input logic mdv);
        st[c] = s; iv[c] = ivv; lim[c] = limv; md[c] = mdv;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < NCH; i++) begin
                chk($sformatf("cnt[%0d]", i),  cnt_bus[i*W +: W], m_cnt[i]);
                chk($sformatf("tick[%0d]", i), {31'd0, tick_bus[i]}, {31'd0, m_tick[i]});
                chk($sformatf("done[%0d]", i), {31'd0, done_bus[i]}, {31'd0, m_done[i]});
            end
            chk("cnt_s",  {28'd0, cnt_s}, m_cnt[NCH]);
            chk("tick_s", {31'd0, tick_s}, {31'd0, m_tick[NCH]});
            chk("done_s", {31'd0, done_s}, {31'd0, m_done[NCH]});
        end
    end

    function automatic logic [31:0] dcnt(input int c);
        return cnt_bus[c*W +: W];
    endfunction

    initial begin
        int seq_cnt [7];
        int seq_done[7];
        seq_cnt  = '{1, 2, 0, 1, 2, 0, 1};
        seq_done = '{0, 0, 1, 0, 0, 1, 0};

        for (int i = 0; i < NCH + 1; i++) begin
            m_tic[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_done[i] = 0;
        end
        for (int i = 0; i < NCH; i++) set_ch(i, 8'd1, 0, 5, 1'b0);
        st_s = 8'd1; iv_s = 4'd0; lim_s = 4'd3; md_s = 1'b0;

        // Reset dominates RUN on all channels
        rst = 1'b1;
        cycle();
        check_en = 1'b1;
        cycle();
        for (int i = 0; i < NCH; i++) begin
            chk("rst_cnt", dcnt(i), 32'd0);
            chk("rst_tick_done", {30'd0, tick_bus[i], done_bus[i]}, 32'd0);
        end
        for (int i = 0; i < NCH; i++) set_ch(i, 8'd2, 0, 5, 1'b0);
        st_s = 8'd2;
        rst = 1'b0;

        // Prescaler: interval 3 -> first increment on 4th RUN edge, then every 4
        set_ch(0, 8'd1, 3, 100, 1'b0);
        set_ch(2, 8'd1, 3, 50, 1'b0);
        cycles(3);
        chk("pre_cnt_e3", dcnt(0), 32'd0);
        chk("pre_tick_e3", {31'd0, tick_bus[0]}, 32'd0);
        cycle();
        chk("pre_cnt_e4", dcnt(0), 32'd1);
        chk("pre_tick_e4", {31'd0, tick_bus[0]}, 32'd1);
        cycle();
        chk("pre_tick_e5", {31'd0, tick_bus[0]}, 32'd0);
        cycles(3);
        chk("pre_cnt_e8", dcnt(0), 32'd2);
        chk("pre_tick_e8", {31'd0, tick_bus[0]}, 32'd1);

        // WRAP interval 0 limit 2
        set_ch(0, 8'd0, 0, 2, 1'b0);
        cycle();
        set_ch(0, 8'd1, 0, 2, 1'b0);
        for (int k = 0; k < 7; k++) begin
            cycle();
            chk($sformatf("wrap_cnt_%0d", k), dcnt(0), 32'(seq_cnt[k]));
            chk($sformatf("wrap_done_%0d", k), {31'd0, done_bus[0]}, 32'(seq_done[k]));
        end

        // ONESHOT interval 1 limit 3
        set_ch(0, 8'd0, 1, 3, 1'b1);
        cycle();
        set_ch(0, 8'd1, 1, 3, 1'b1);
        cycles(5);
        chk("os_cnt_e5", dcnt(0), 32'd2);
        chk("os_done_e5", {31'd0, done_bus[0]}, 32'd0);
        cycle();
        chk("os_cnt_e6", dcnt(0), 32'd3);
        chk("os_done_e6", {31'd0, done_bus[0]}, 32'd1);
        cycles(10);
        chk("os_cnt_hold", dcnt(0), 32'd3);
        chk("os_tick_hold", {31'd0, tick_bus[0]}, 32'd0);
        chk("os_done_hold", {31'd0, done_bus[0]}, 32'd1);
        set_ch(0, 8'd0, 1, 3, 1'b1);
        cycle();
        chk("os_reset_cnt", dcnt(0), 32'd0);
        chk("os_reset_done", {31'd0, done_bus[0]}, 32'd0);
        set_ch(0, 8'd2, 1, 3, 1'b1);

        // HALT preserves tic: resume needs 3 more RUN edges with interval 4
        set_ch(1, 8'd0, 4, 100, 1'b0);
        cycle();
        set_ch(1, 8'd1, 4, 100, 1'b0);
        cycles(2);
        set_ch(1, 8'd2, 4, 100, 1'b0);
        cycles(5);
        chk("halt_cnt", dcnt(1), 32'd0);
        set_ch(1, 8'd1, 4, 100, 1'b0);
        cycles(2);
        chk("resume_cnt_r2", dcnt(1), 32'd0);
        cycle();
        chk("resume_cnt_r3", dcnt(1), 32'd1);
        chk("resume_tick_r3", {31'd0, tick_bus[1]}, 32'd1);

        // Lowering interval below tic fires on the next edge
        set_ch(3, 8'd0, 10, 1000, 1'b0);
        cycle();
        set_ch(3, 8'd1, 10, 1000, 1'b0);
        cycles(7);
        chk("lower_cnt_before", dcnt(3), 32'd0);
        iv[3] = 2;
        cycle();
        chk("lower_cnt_after", dcnt(3), 32'd1);
        chk("lower_tick_after", {31'd0, tick_bus[3]}, 32'd1);

        // ONESHOT with limit 0: done without increment
        set_ch(3, 8'd0, 0, 0, 1'b1);
        cycle();
        set_ch(3, 8'd1, 0, 0, 1'b1);
        cycle();
        chk("lim0_done", {31'd0, done_bus[3]}, 32'd1);
        chk("lim0_cnt", dcnt(3), 32'd0);
        chk("lim0_tick", {31'd0, tick_bus[3]}, 32'd0);

        // Unknown state code acts as HALT
        set_ch(3, 8'd0, 0, 100, 1'b0);
        cycle();
        set_ch(3, 8'd1, 0, 100, 1'b0);
        cycles(3);
        st[3] = 8'd5;
        cycles(4);
        chk("code5_cnt", dcnt(3), 32'd3);
        chk("code5_tick", {31'd0, tick_bus[3]}, 32'd0);

        // WIDTH=4, limit 15: 15 -> 0 with done pulse
        st_s = 8'd0;
        cycle();
        st_s = 8'd1; iv_s = 4'd0; lim_s = 4'd15; md_s = 1'b0;
        cycles(15);
        chk("w4_cnt_15", {28'd0, cnt_s}, 32'd15);
        chk("w4_done_15", {31'd0, done_s}, 32'd0);
        cycle();
        chk("w4_cnt_wrap", {28'd0, cnt_s}, 32'd0);
        chk("w4_done_wrap", {31'd0, done_s}, 32'd1);

        // Random traffic on all channels
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NCH + 1; i++) begin
                logic [7:0] s;
                int r;
                r = $urandom_range(0, 19);
                if (r == 0)      s = 8'd0;
                else if (r < 3)  s = 8'd2;
                else if (r == 3) s = 8'($urandom_range(3, 255));
                else             s = 8'd1;
                if (i < NCH) begin
                    st[i] = s;
                    if ($urandom_range(0, 7) == 0)  iv[i]  = $urandom_range(0, 5);
                    if ($urandom_range(0, 7) == 0)  lim[i] = $urandom_range(0, 6);
                    if ($urandom_range(0, 15) == 0) md[i]  = 1'($urandom_range(0, 1));
                end else begin
                    st_s = s;
                    if ($urandom_range(0, 7) == 0)  iv_s  = 4'($urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0)  lim_s = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 15) == 0) md_s  = 1'($urandom_range(0, 1));
                end
            end
            cycle();
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
